// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the hazard/forwarding unit
package rv32i_types;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } hazard_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   localparam int FWD_SEL_W = 2;
   typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + {5'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-register bitmap for long-latency results
module reg_scoreboard
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        set_en,
   input  logic [4:0]  set_rd,
   input  logic        clr_en,
   input  logic [4:0]  clr_rd,
   output logic [31:0] pend_map,
   output logic [5:0]  pend_cnt
);

   logic [31:0] pend_nxt;

   // Set is applied after clear so an issue/done collision leaves the bit set.
   always_comb begin
      pend_nxt = pend_map;
      if (clr_en) begin
         pend_nxt[clr_rd] = 1'b0;
      end
      if (set_en && (set_rd != REG_X0)) begin
         pend_nxt[set_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_map <= '0;
      end else begin
         pend_map <= pend_nxt;
      end
   end

   assign pend_cnt = popcount32(pend_map);

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - operand forwarding, load-use and scoreboard stall control (HAZARD_DEC_BYPASS_EN)
module hazard_fwd_unit
   import rv32i_types::*;
#(
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int SELW    = $clog2(NUM_FWD + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC*5-1:0]    src_exe,
   input  logic [NUM_SRC*5-1:0]    src_dec,
   input  logic [NUM_FWD*5-1:0]    fwd_rd,
   input  logic [NUM_FWD-1:0]      fwd_we,
   input  logic [NUM_FWD-1:0]      fwd_load,
   input  logic                    long_issue,
   input  logic [4:0]              long_rd,
   input  logic                    long_done,
   input  logic [4:0]              long_done_rd,
   input  logic                    dmem_busy,
   output logic [NUM_SRC*SELW-1:0] fwd_sel,
   output logic [NUM_SRC-1:0]      dec_bypass,
   output logic                    stall,
   output logic                    bubble,
   output logic [5:0]              pend_cnt
);

   hazard_state_t state, state_nxt;
   logic [31:0]        pend_map;
   logic               lu_hit;
   logic               dec_pend_hit;
   logic               dec_raw_stall;
   logic [NUM_SRC-1:0] dec_old;
   logic [4:0]         old_rd;
   logic               unused_fwd_load;

   assign old_rd          = fwd_rd[(NUM_FWD-1)*5 +: 5];
   assign unused_fwd_load = &{1'b0, fwd_load};

   reg_scoreboard u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (long_issue),
      .set_rd   (long_rd),
      .clr_en   (long_done),
      .clr_rd   (long_done_rd),
      .pend_map (pend_map),
      .pend_cnt (pend_cnt)
   );

   // Walk oldest to youngest so the youngest matching stage wins.
   always_comb begin
      fwd_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we[k] && (fwd_rd[k*5 +: 5] != REG_X0) &&
                (fwd_rd[k*5 +: 5] == src_exe[s*5 +: 5])) begin
               fwd_sel[s*SELW +: SELW] = SELW'(k + 1);
            end
         end
      end
   end

   always_comb begin
      lu_hit       = 1'b0;
      dec_pend_hit = 1'b0;
      dec_old      = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (fwd_load[0] && fwd_we[0] && (fwd_rd[4:0] != REG_X0) &&
             (src_exe[s*5 +: 5] == fwd_rd[4:0])) begin
            lu_hit = 1'b1;
         end
         if ((src_dec[s*5 +: 5] != REG_X0) && pend_map[src_dec[s*5 +: 5]]) begin
            dec_pend_hit = 1'b1;
         end
         if (fwd_we[NUM_FWD-1] && (old_rd != REG_X0) && (old_rd == src_dec[s*5 +: 5])) begin
            dec_old[s] = 1'b1;
         end
      end
   end

`ifdef HAZARD_DEC_BYPASS_EN
   assign dec_bypass    = dec_old;
   assign dec_raw_stall = 1'b0;
`else
   assign dec_bypass    = '0;
   assign dec_raw_stall = |dec_old;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // MEM_WAIT holds the stall through the cycle busy drops; the response is consumed then.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bubble    = 1'b0;
      case (state)
         RUN: begin
            stall = dec_pend_hit | dec_raw_stall;
            if (lu_hit) begin
               state_nxt = LU_STALL;
            end else if (dmem_busy) begin
               state_nxt = MEM_WAIT;
            end
         end
         LU_STALL: begin
            stall     = 1'b1;
            bubble    = 1'b1;
            state_nxt = dmem_busy ? MEM_WAIT : RUN;
         end
         MEM_WAIT: begin
            stall = 1'b1;
            if (!dmem_busy) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed self-checking bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

   logic        clk;
   logic        rst;
   logic [9:0]  src_exe;
   logic [9:0]  src_dec;
   logic [9:0]  fwd_rd;
   logic [1:0]  fwd_we;
   logic [1:0]  fwd_load;
   logic        long_issue;
   logic [4:0]  long_rd;
   logic        long_done;
   logic [4:0]  long_done_rd;
   logic        dmem_busy;
   logic [3:0]  fwd_sel;
   logic [1:0]  dec_bypass;
   logic        stall;
   logic        bubble;
   logic [5:0]  pend_cnt;

   int checks = 0;
   int errors = 0;

   hazard_fwd_unit dut (
      .clk          (clk),
      .rst          (rst),
      .src_exe      (src_exe),
      .src_dec      (src_dec),
      .fwd_rd       (fwd_rd),
      .fwd_we       (fwd_we),
      .fwd_load     (fwd_load),
      .long_issue   (long_issue),
      .long_rd      (long_rd),
      .long_done    (long_done),
      .long_done_rd (long_done_rd),
      .dmem_busy    (dmem_busy),
      .fwd_sel      (fwd_sel),
      .dec_bypass   (dec_bypass),
      .stall        (stall),
      .bubble       (bubble),
      .pend_cnt     (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      src_exe = '0; src_dec = '0; fwd_rd = '0; fwd_we = '0; fwd_load = '0;
      long_issue = 0; long_rd = '0; long_done = 0; long_done_rd = '0; dmem_busy = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1; dmem_busy = 1;
      tick(); tick();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %0b expected 0", bubble); end
      checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_pend: got %0d expected 0", pend_cnt); end
      dmem_busy = 0;
      tick();
      rst = 0;
      tick();
   endtask

   task automatic test_fwd_priority();
      clear_inputs();
      fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; src_exe = {5'd0, 5'd5};
      #1;
      checks++; if (fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL fwd_youngest: got %0d expected 1", fwd_sel[1:0]); end
      checks++; if (fwd_sel[3:2] !== 2'd0) begin errors++; $display("FAIL fwd_src1_none: got %0d expected 0", fwd_sel[3:2]); end
      fwd_rd = {5'd5, 5'd3}; src_exe = {5'd3, 5'd5};
      #1;
      checks++; if (fwd_sel[1:0] !== 2'd2) begin errors++; $display("FAIL fwd_oldest: got %0d expected 2", fwd_sel[1:0]); end
      checks++; if (fwd_sel[3:2] !== 2'd1) begin errors++; $display("FAIL fwd_src1_mem: got %0d expected 1", fwd_sel[3:2]); end
      fwd_we = 2'b10; fwd_rd = {5'd5, 5'd5}; src_exe = {5'd0, 5'd5};
      #1;
      checks++; if (fwd_sel[1:0] !== 2'd2) begin errors++; $display("FAIL fwd_we_gate: got %0d expected 2", fwd_sel[1:0]); end
      tick();
   endtask

   task automatic test_x0();
      clear_inputs();
      fwd_we = 2'b11; fwd_load = 2'b01; fwd_rd = '0; src_exe = '0; src_dec = '0;
      #1;
      checks++; if (fwd_sel !== 4'd0) begin errors++; $display("FAIL x0_fwd: got %0d expected 0", fwd_sel); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b expected 0", stall); end
      tick();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_no_lu: got %0b expected 0", stall); end
      checks++; if (dec_bypass !== 2'b00) begin errors++; $display("FAIL x0_bypass: got %0b expected 00", dec_bypass); end
      clear_inputs();
      tick();
   endtask

   task automatic test_load_use();
      clear_inputs();
      fwd_load = 2'b01; fwd_we = 2'b01; fwd_rd = {5'd0, 5'd7}; src_exe = {5'd7, 5'd0};
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_detect_stall: got %0b expected 0", stall); end
      checks++; if (fwd_sel[3:2] !== 2'd1) begin errors++; $display("FAIL lu_detect_sel: got %0d expected 1", fwd_sel[3:2]); end
      tick();
      fwd_load = 2'b00; fwd_we = 2'b10; fwd_rd = {5'd7, 5'd0};
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b expected 1", stall); end
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %0b expected 1", bubble); end
      checks++; if (fwd_sel[3:2] !== 2'd2) begin errors++; $display("FAIL lu_fwd_during_stall: got %0d expected 2", fwd_sel[3:2]); end
      tick();
      clear_inputs();
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release_stall: got %0b expected 0", stall); end
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL lu_release_bubble: got %0b expected 0", bubble); end
      tick();
   endtask

   task automatic test_lu_mem_wait();
      logic [5:0] exp_stall;
      logic [5:0] exp_bubble;
      logic [5:0] busy_seq;
      int         stall_total;
      exp_stall   = 6'b011110;
      exp_bubble  = 6'b000010;
      busy_seq    = 6'b001110;
      stall_total = 0;
      clear_inputs();
      for (int c = 0; c < 6; c++) begin
         if (c == 0) begin
            fwd_load = 2'b01; fwd_we = 2'b01; fwd_rd = {5'd0, 5'd4}; src_exe = {5'd0, 5'd4};
         end else begin
            fwd_load = 2'b00; fwd_we = 2'b00; src_exe = '0;
         end
         dmem_busy = busy_seq[c];
         #1;
         if (stall === 1'b1) stall_total++;
         checks++; if (stall !== exp_stall[c]) begin errors++; $display("FAIL memwait_stall_c%0d: got %0b expected %0b", c, stall, exp_stall[c]); end
         checks++; if (bubble !== exp_bubble[c]) begin errors++; $display("FAIL memwait_bubble_c%0d: got %0b expected %0b", c, bubble, exp_bubble[c]); end
         tick();
      end
      checks++; if (stall_total != 4) begin errors++; $display("FAIL memwait_stall_total: got %0d expected 4", stall_total); end
      clear_inputs();
   endtask

   task automatic test_scoreboard();
      clear_inputs();
      src_dec = {5'd0, 5'd9};
      long_issue = 1; long_rd = 5'd9;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_c0_stall: got %0b expected 0", stall); end
      tick();
      long_issue = 0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) begin long_done = 1; long_done_rd = 5'd9; end
         #1;
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_c%0d: got %0b expected 1", c, stall); end
         checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_pend_c%0d: got %0d expected 1", c, pend_cnt); end
         tick();
      end
      long_done = 0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_c5_stall: got %0b expected 0", stall); end
      checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL sb_c5_pend: got %0d expected 0", pend_cnt); end
      long_issue = 1; long_rd = 5'd9; long_done = 1; long_done_rd = 5'd9;
      tick();
      long_issue = 1; long_rd = 5'd0; long_done = 0;
      #1;
      checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_collide_set: got %0d expected 1", pend_cnt); end
      tick();
      long_issue = 0; long_done = 1; long_done_rd = 5'd9;
      #1;
      checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_x0_issue: got %0d expected 1", pend_cnt); end
      tick();
      long_done = 0;
      #1;
      checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL sb_final_clear: got %0d expected 0", pend_cnt); end
      clear_inputs();
      tick();
   endtask

   task automatic test_dec_oldest();
      clear_inputs();
      fwd_we = 2'b10; fwd_rd = {5'd12, 5'd0}; src_dec = {5'd12, 5'd0};
      #1;
`ifdef HAZARD_DEC_BYPASS_EN
      checks++; if (dec_bypass !== 2'b10) begin errors++; $display("FAIL dec_bypass: got %0b expected 10", dec_bypass); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dec_bypass_stall: got %0b expected 0", stall); end
`else
      checks++; if (dec_bypass !== 2'b00) begin errors++; $display("FAIL dec_bypass_off: got %0b expected 00", dec_bypass); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dec_raw_stall: got %0b expected 1", stall); end
`endif
      tick();
      fwd_we = 2'b00;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dec_raw_release: got %0b expected 0", stall); end
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mem_wait();
      clear_inputs();
      for (int r = 1; r <= 3; r++) begin
         long_issue = 1; long_rd = 5'(r);
         tick();
      end
      long_issue = 0; dmem_busy = 1;
      #1;
      checks++; if (pend_cnt !== 6'd3) begin errors++; $display("FAIL rstmw_pend3: got %0d expected 3", pend_cnt); end
      tick();
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmw_in_wait: got %0b expected 1", stall); end
      rst = 1; long_issue = 1; long_rd = 5'd4;
      tick();
      rst = 0; long_issue = 0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmw_stall: got %0b expected 0", stall); end
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL rstmw_bubble: got %0b expected 0", bubble); end
      checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL rstmw_pend: got %0d expected 0", pend_cnt); end
      dmem_busy = 0;
      tick();
      clear_inputs();
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_fwd_priority();
      test_x0();
      test_load_use();
      test_lu_mem_wait();
      test_scoreboard();
      test_dec_oldest();
      test_reset_mem_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
